// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// FIFO_UART_TX_PARITY_EN adds an even-parity bit after the data bits.
package fifo_uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 16;
    localparam int unsigned DATA_W           = 8;
    localparam int unsigned CNT_W            = 16;
    localparam int unsigned BIT_IDX_W        = 3;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_POP    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
        ST_PARITY = 3'd5,
`endif
        ST_STOP   = 3'd6
    } state_t;

`ifdef FIFO_UART_TX_PARITY_EN
    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
`endif

endpackage

// File: rtl/baud_tick_gen.sv
// Bit timer: counts 0..CLKS_PER_BIT-1, flags the terminal count, restarts on clr.
module baud_tick_gen
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             tick_c
);

    localparam logic [CNT_W-1:0] TC = CNT_W'(CLKS_PER_BIT - 1);

    assign tick_c = (cnt == TC);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops bytes from a registered-output FIFO and serialises them 8N1.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned DATA_W       = fifo_uart_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              buf_empty,
    input  logic [DATA_W-1:0] buf_out,
    output logic              rd_en,
    output logic              tx,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam logic [BIT_IDX_W-1:0] LAST_BIT  = BIT_IDX_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]     DONE_PRE  = CNT_W'(CLKS_PER_BIT - 2);

    state_t                 state_q, state_d;
    logic [DATA_W-1:0]      sh_q, sh_d;
    logic [BIT_IDX_W-1:0]   bit_q, bit_d;
    logic                   clr_c;
    logic                   tick_c;
    logic [CNT_W-1:0]       cnt;
    logic                   tx_d, rd_en_d, busy_d, done_d;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                   par_q, par_d;
`endif

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr_c),
        .cnt    (cnt),
        .tick_c (tick_c)
    );

    // Next state, shift register and bit-timer clear
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        clr_c   = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                clr_c = 1'b1;
                if (!buf_empty) begin
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                clr_c   = 1'b1;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                clr_c   = 1'b1;
                sh_d    = buf_out;
                bit_d   = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                par_d   = even_parity(buf_out);
`endif
                state_d = ST_START;
            end
            ST_START: begin
                if (tick_c) begin
                    clr_c   = 1'b1;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick_c) begin
                    clr_c = 1'b1;
                    sh_d  = sh_q >> 1;
                    if (bit_q == LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + BIT_IDX_W'(1);
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick_c) begin
                    clr_c   = 1'b1;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick_c) begin
                    clr_c   = 1'b1;
                    state_d = buf_empty ? ST_IDLE : ST_POP;
                end
            end
            default: begin
                clr_c   = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values for the cycle following this edge, derived from the next state
    always_comb begin
        tx_d    = LINE_IDLE;
        rd_en_d = (state_d == ST_POP);
        busy_d  = (state_d != ST_IDLE);
        // tx_done lands on the cycle where the counter reaches its terminal value in STOP
        done_d  = (state_q == ST_STOP) && (cnt == DONE_PRE);
        case (state_d)
            ST_START:  tx_d = LINE_START;
            ST_DATA:   tx_d = sh_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_d;
`endif
            ST_STOP:   tx_d = LINE_STOP;
            default:   tx_d = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            bit_q   <= '0;
            rd_en   <= 1'b0;
            tx      <= LINE_IDLE;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            rd_en   <= rd_en_d;
            tx      <= tx_d;
            tx_busy <= busy_d;
            tx_done <= done_d;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: two instances (16 and 2 clocks per bit) fed by simple FIFO models.
module tb_fifo_uart_tx;

    localparam int unsigned CA = 16;
    localparam int unsigned CB = 2;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       a_empty, b_empty;
    logic [7:0] a_out = 8'h00, b_out = 8'h00;
    logic       a_rd, b_rd, a_tx, b_tx, a_busy, b_busy, a_done, b_done;

    logic [7:0] a_mem [256];
    logic [7:0] b_mem [256];
    logic [7:0] a_wp = 8'd0, a_rp = 8'd0, b_wp = 8'd0, b_rp = 8'd0;
    int a_rd_cnt = 0, a_done_cnt = 0, b_rd_cnt = 0, b_done_cnt = 0;
    int n_cmp = 0, n_fail = 0;
    int n;

    assign a_empty = (a_wp == a_rp);
    assign b_empty = (b_wp == b_rp);

    // FIFO models: registered read data, valid the cycle after rd_en
    always @(posedge clk) begin
        if (a_rd) begin
            a_out <= a_mem[a_rp];
            a_rp  <= a_rp + 8'd1;
        end
        if (b_rd) begin
            b_out <= b_mem[b_rp];
            b_rp  <= b_rp + 8'd1;
        end
        if (a_rd)   a_rd_cnt   <= a_rd_cnt + 1;
        if (a_done) a_done_cnt <= a_done_cnt + 1;
        if (b_rd)   b_rd_cnt   <= b_rd_cnt + 1;
        if (b_done) b_done_cnt <= b_done_cnt + 1;
    end

    fifo_uart_tx #(.CLKS_PER_BIT(CA)) u_a (
        .clk(clk), .rst(rst), .buf_empty(a_empty), .buf_out(a_out),
        .rd_en(a_rd), .tx(a_tx), .tx_busy(a_busy), .tx_done(a_done)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(CB)) u_b (
        .clk(clk), .rst(rst), .buf_empty(b_empty), .buf_out(b_out),
        .rd_en(b_rd), .tx(b_tx), .tx_busy(b_busy), .tx_done(b_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic g_tx(input int sel);   return (sel == 0) ? a_tx   : b_tx;   endfunction
    function automatic logic g_rd(input int sel);   return (sel == 0) ? a_rd   : b_rd;   endfunction
    function automatic logic g_busy(input int sel); return (sel == 0) ? a_busy : b_busy; endfunction
    function automatic logic g_done(input int sel); return (sel == 0) ? a_done : b_done; endfunction

    task automatic push(input int sel, input logic [7:0] b);
        if (sel == 0) begin
            a_mem[a_wp] = b;
            a_wp = a_wp + 8'd1;
        end else begin
            b_mem[b_wp] = b;
            b_wp = b_wp + 8'd1;
        end
    endtask

    task automatic wait_rd(input int sel, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!g_rd(sel) && cnt < 200);
    endtask

    // One bit period: tx level, tx_done only on its final cycle when last_done is set
    task automatic phase(input int sel, input int c, input logic exp, input logic last_done,
                         input string tag, inout int len);
        for (int k = 0; k < c; k++) begin
            @(negedge clk);
            len++;
            chk({tag, ".tx"},   32'(g_tx(sel)),   32'(exp));
            chk({tag, ".done"}, 32'(g_done(sel)), 32'(last_done && (k == c - 1)));
            chk({tag, ".busy"}, 32'(g_busy(sel)), 32'd1);
            chk({tag, ".rd"},   32'(g_rd(sel)),   32'd0);
        end
    endtask

    // Entered on the negedge of the POP cycle; returns on the negedge of the last STOP cycle
    task automatic frame(input int sel, input logic [7:0] b, input string tag);
        int c;
        int len;
        c = (sel == 0) ? CA : CB;
        len = 0;
        chk({tag, ".pop_rd"},   32'(g_rd(sel)),   32'd1);
        chk({tag, ".pop_tx"},   32'(g_tx(sel)),   32'd1);
        chk({tag, ".pop_busy"}, 32'(g_busy(sel)), 32'd1);
        @(negedge clk);
        chk({tag, ".load_rd"},  32'(g_rd(sel)),   32'd0);
        chk({tag, ".load_tx"},  32'(g_tx(sel)),   32'd1);
        phase(sel, c, 1'b0, 1'b0, {tag, ".start"}, len);
        for (int i = 0; i < 8; i++) begin
            phase(sel, c, b[i], 1'b0, {tag, ".data"}, len);
        end
`ifdef FIFO_UART_TX_PARITY_EN
        phase(sel, c, ^b, 1'b0, {tag, ".parity"}, len);
`endif
        phase(sel, c, 1'b1, 1'b1, {tag, ".stop"}, len);
        chk({tag, ".len"}, 32'(len), 32'(FRAME_BITS * c));
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.a_tx",   32'(a_tx),   32'd1);
        chk("rst.a_rd",   32'(a_rd),   32'd0);
        chk("rst.a_busy", 32'(a_busy), 32'd0);
        chk("rst.a_done", 32'(a_done), 32'd0);
        chk("rst.b_tx",   32'(b_tx),   32'd1);
        chk("rst.b_busy", 32'(b_busy), 32'd0);
        rst = 1'b1;

        // Empty FIFO: line stays idle
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            chk("idle.a_rd",   32'(a_rd),   32'd0);
            chk("idle.a_tx",   32'(a_tx),   32'd1);
            chk("idle.a_busy", 32'(a_busy), 32'd0);
            chk("idle.b_rd",   32'(b_rd),   32'd0);
            chk("idle.b_tx",   32'(b_tx),   32'd1);
            chk("idle.b_busy", 32'(b_busy), 32'd0);
        end

        // Single byte 0xA5
        push(0, 8'hA5);
        wait_rd(0, n);
        chk("a5.latency", 32'(n), 32'd1);
        frame(0, 8'hA5, "a5");
        @(negedge clk);
        chk("a5.after_tx",   32'(a_tx),   32'd1);
        chk("a5.after_busy", 32'(a_busy), 32'd0);
        chk("a5.after_rd",   32'(a_rd),   32'd0);
        chk("a5.rd_cnt",     32'(a_rd_cnt),   32'd1);
        chk("a5.done_cnt",   32'(a_done_cnt), 32'd1);

        // Back-to-back 0x00, 0xFF: STOP is followed directly by POP and LOAD
        push(0, 8'h00);
        push(0, 8'hFF);
        wait_rd(0, n);
        chk("b2b.latency", 32'(n), 32'd1);
        frame(0, 8'h00, "b2b0");
        @(negedge clk);
        frame(0, 8'hFF, "b2b1");
        @(negedge clk);
        chk("b2b.after_busy", 32'(a_busy),     32'd0);
        chk("b2b.rd_cnt",     32'(a_rd_cnt),   32'd3);
        chk("b2b.done_cnt",   32'(a_done_cnt), 32'd3);

        // Reset during DATA bit 3 of 0x3C; next frame must carry 0x5A
        push(0, 8'h3C);
        push(0, 8'h5A);
        wait_rd(0, n);
        chk("abort.latency", 32'(n), 32'd1);
        repeat (1 + CA + 3 * CA + 5) @(negedge clk);
        chk("abort.pre_busy", 32'(a_busy), 32'd1);
        chk("abort.pre_tx",   32'(a_tx),   32'd1);
        #1 rst = 1'b0;
        #1;
        chk("abort.tx",   32'(a_tx),   32'd1);
        chk("abort.busy", 32'(a_busy), 32'd0);
        chk("abort.done", 32'(a_done), 32'd0);
        chk("abort.rd",   32'(a_rd),   32'd0);
        repeat (3) @(negedge clk);
        chk("abort.hold_tx", 32'(a_tx), 32'd1);
        rst = 1'b1;
        chk("abort.done_cnt", 32'(a_done_cnt), 32'd3);
        wait_rd(0, n);
        chk("resume.latency", 32'(n), 32'd1);
        frame(0, 8'h5A, "resume");
        @(negedge clk);
        chk("resume.rd_cnt",   32'(a_rd_cnt),   32'd5);
        chk("resume.done_cnt", 32'(a_done_cnt), 32'd4);
        chk("resume.busy",     32'(a_busy),     32'd0);

`ifdef FIFO_UART_TX_PARITY_EN
        // Parity: 0x07 odd weight -> 1, 0x03 even weight -> 0
        push(0, 8'h07);
        push(0, 8'h03);
        wait_rd(0, n);
        chk("par.latency", 32'(n), 32'd1);
        frame(0, 8'h07, "par07");
        @(negedge clk);
        frame(0, 8'h03, "par03");
        @(negedge clk);
        chk("par.busy", 32'(a_busy), 32'd0);
`endif

        // Two clocks per bit, four queued bytes
        push(1, 8'h12);
        push(1, 8'h34);
        push(1, 8'h56);
        push(1, 8'h78);
        wait_rd(1, n);
        chk("fast.latency", 32'(n), 32'd1);
        frame(1, 8'h12, "fast0");
        @(negedge clk);
        frame(1, 8'h34, "fast1");
        @(negedge clk);
        frame(1, 8'h56, "fast2");
        @(negedge clk);
        frame(1, 8'h78, "fast3");
        @(negedge clk);
        chk("fast.busy",     32'(b_busy),     32'd0);
        chk("fast.tx",       32'(b_tx),       32'd1);
        chk("fast.empty",    32'(b_empty),    32'd1);
        chk("fast.rd_cnt",   32'(b_rd_cnt),   32'd4);
        chk("fast.done_cnt", 32'(b_done_cnt), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
